// File: rtl/axil_master_seq.sv
// ---------------------------------------------------------------------------
// axil_master_seq
//
// Single-outstanding AXI4-Lite master sequencer. One command (read or write)
// on the cmd_* handshake becomes one complete AXI4-Lite transaction. The
// result is returned on the rsp_* handshake. A new command is accepted only
// after the previous response has been consumed.
//
// Ports
//   ACLK, ARESETn         clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready is high only when idle
//   cmd_write             1 = write, 0 = read
//   cmd_addr, cmd_wdata   target address and write data
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata, rsp_resp   read data (0 for writes) and captured BRESP/RRESP
//   AW*/W*/B*/AR*/R*      AXI4-Lite master channels toward the slave
// ---------------------------------------------------------------------------
module axil_master_seq #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RVALID,
    output logic                  RREADY
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RSP
    } state_t;

    state_t                  state_q,     state_d;
    logic                    awvalid_q,   awvalid_d;
    logic                    wvalid_q,    wvalid_d;
    logic                    arvalid_q,   arvalid_d;
    logic                    bready_q,    bready_d;
    logic                    rready_q,    rready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    aw_done_q,   aw_done_d;
    logic                    w_done_q,    w_done_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q,    awaddr_d;
    logic [ADDR_WIDTH-1:0]   araddr_q,    araddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,     wdata_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q,  rsp_resp_d;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic aw_done_now;
    logic w_done_now;

    assign aw_hs = awvalid_q & AWREADY;
    assign w_hs  = wvalid_q  & WREADY;
    assign ar_hs = arvalid_q & ARREADY;

    // AW and W complete independently; either may finish first or both in
    // the same cycle, so "done" includes a handshake happening right now.
    assign aw_done_now = aw_done_q | aw_hs;
    assign w_done_now  = w_done_q  | w_hs;

    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = WR_REQ;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                end
                aw_done_d = aw_done_now;
                w_done_d  = w_done_now;
                if (aw_done_now && w_done_now) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    bready_d  = 1'b1;
                    state_d   = WR_RESP;
                end
            end
            WR_RESP: begin
                if (BVALID && bready_q) begin
                    rsp_resp_d  = BRESP;
                    rsp_rdata_d = '0;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RD_REQ: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (RVALID && rready_q) begin
                    rsp_rdata_d = RDATA;
                    rsp_resp_d  = RRESP;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    // Idle decode only; deliberately independent of cmd_valid.
    assign cmd_ready = (state_q == IDLE);

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign AWADDR    = awaddr_q;
    assign AWVALID   = awvalid_q;
    assign WDATA     = wdata_q;
    assign WVALID    = wvalid_q;
    assign BREADY    = bready_q;
    assign ARADDR    = araddr_q;
    assign ARVALID   = arvalid_q;
    assign RREADY    = rready_q;

endmodule

// File: doc/axil_master_seq.md
Name: axil_master_seq

Overview:
- Single-outstanding AXI4-Lite master sequencer.
- Converts a simple command/response handshake (one read or write per command) into correctly ordered AXI4-Lite channel activity on an axi_if-style bus toward the register-slave DUT.
- Used by firmware-model and self-test logic to configure and read back the slave without bit-banging channels.

Parameters:
ADDR_WIDTH, 4, address width of cmd_addr and AWADDR/ARADDR
DATA_WIDTH, 32, data width of cmd_wdata, rsp_rdata, WDATA, RDATA

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESETn  in  1  reset; one clock, asynchronous assert, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  sequencer idle, command accepted when cmd_valid&cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  target address
cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
rsp_valid  out  1  response available
rsp_ready  in  1  response consumer ready
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
rsp_resp  out  2  captured BRESP or RRESP
AWADDR  out  ADDR_WIDTH  write address
AWVALID  out  1
AWREADY  in  1
WDATA  out  DATA_WIDTH  write data
WVALID  out  1
WREADY  in  1
BRESP  in  2
BVALID  in  1
BREADY  out  1
ARADDR  out  ADDR_WIDTH  read address
ARVALID  out  1
ARREADY  in  1
RDATA  in  DATA_WIDTH
RRESP  in  2
RVALID  in  1
RREADY  out  1

Behaviour:
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- Reset (ARESETn=0, asynchronous): state=IDLE; AWVALID/WVALID/ARVALID/BREADY/RREADY/rsp_valid=0; AWADDR/ARADDR/WDATA/rsp_rdata=0; rsp_resp=2'b00. cmd_ready=1 (decode of IDLE).
- cmd_ready = (state==IDLE), combinational from state only; never depends on cmd_valid.
- IDLE, accept with cmd_write=1: latch addr/data into AWADDR/WDATA; next cycle AWVALID=WVALID=1; state WR_REQ.
- IDLE, accept with cmd_write=0: latch ARADDR; next cycle ARVALID=1; state RD_REQ.
- WR_REQ:
  - AW and W tracked independently (aw_done, w_done flags).
  - AWVALID drops the cycle after AWREADY sampled high; WVALID likewise with WREADY.
  - Handshakes may occur in either order or the same cycle.
  - When both done: state WR_RESP, BREADY=1 next cycle.
- WR_RESP: on BVALID&BREADY, capture BRESP into rsp_resp, rsp_rdata=0, BREADY=0, rsp_valid=1, state RSP.
- RD_REQ: ARVALID drops after ARREADY handshake; next cycle state RD_DATA with RREADY=1.
- RD_DATA: on RVALID&RREADY, capture RDATA/RRESP, RREADY=0, rsp_valid=1, state RSP.
- RSP: rsp_valid and rsp data held stable until rsp_ready=1; then rsp_valid=0, state IDLE. A new command is accepted no earlier than the cycle after the response handshake.
- AXI rules: all VALIDs, once high, stay high with stable address/data until handshake. VALID never waits on READY. BREADY/RREADY are only high in WR_RESP/RD_DATA.
- Stray BVALID/RVALID outside WR_RESP/RD_DATA: ignored; no state change.
- Non-OKAY responses (2'b10, 2'b11) are passed through unmodified; no retry.
- Zero-wait slave latency:
  - Write: accept at cycle 0, AW/W handshake cycle 1, BREADY cycle 2, B handshake cycle 2, rsp_valid cycle 3.
  - Read: accept 0, AR 1, RREADY 2, rsp_valid 3.
- Reset mid-transaction: everything returns to reset values immediately. Any partial AXI transaction is abandoned; the slave is reset by the same ARESETn.

Test Plan:
- Write addr 0x4, data 0xDEADBEEF, zero-wait slave -> AWVALID&WVALID at cycle 1, rsp_valid at cycle 3 with rsp_resp=00, rsp_rdata=0.
- Read back addr 0x4 -> ARADDR=0x4, RREADY only in RD_DATA; rsp_rdata=0xDEADBEEF, rsp_resp=00 at cycle 3.
- Write with WREADY delayed 3 cycles after AWREADY -> AWVALID drops after cycle 1, WVALID held with stable WDATA until cycle 4, BREADY asserted cycle 5.
- Slave returns RRESP=2'b10 and holds rsp_ready=0 for 5 cycles -> rsp_valid, rsp_resp=10 stable for 5 cycles; cmd_ready=0 throughout; IDLE after handshake.
- ARESETn pulsed low while ARVALID=1 awaiting ARREADY -> ARVALID=0 asynchronously, cmd_ready=1; a subsequent read completes normally.
- Back-to-back 16 random reads/writes against a reference memory -> every rsp matches; no VALID drops before handshake (assertion-checked).
